reqrsp_arbiter: RTL and testbench

//  Shares one req/rsp channel pair among N HDL-side requesters.
//  - Upstream side: the transactor's req valid/ready (HDL->HVL fifo) and rsp valid/ready (HVL->HDL fifo).
//  - Arbitrates requests round-robin and records each grant's requester ID in an in-order tag FIFO.
//  - Steers each returning response to the requester that issued the matching request.
//  - Upstream responses are strictly in request order.

---
 rtl/reqrsp_arb_pkg.sv | 43 ++++
 rtl/reqrsp_tag_fifo.sv | 73 +++++++
 rtl/reqrsp_arbiter.sv | 115 +++++++++++
 tb/tb_reqrsp_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reqrsp_arb_pkg.sv
// Shared types and helpers for the request/response channel arbiter.
// Holds the FSM state encoding, default sizes and the round-robin picker.
package reqrsp_arb_pkg;

  localparam int unsigned NDefault     = 4;
  localparam int unsigned DepthDefault = 4;
  localparam int unsigned WreqDefault  = 32;
  localparam int unsigned WrspDefault  = 32;

  // The picker works on a fixed-width vector so it can live in a package.
  localparam int unsigned MaxN    = 32;
  localparam int unsigned MaxIdxW = 5;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MaxN-1:0] valid,
                                       input int unsigned     ptr,
                                       input int unsigned     n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i < n) begin
        cand = (ptr + i) % n;
        if (!res.found && valid[cand[MaxIdxW-1:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[MaxIdxW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reqrsp_tag_fifo.sv
// In-order FIFO of requester IDs for requests still awaiting a response.
// Only tags are stored; full/empty come from the occupancy count.
module reqrsp_tag_fifo
  import reqrsp_arb_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            push_i,
  input  logic [W-1:0]    tag_i,
  input  logic            pop_i,
  output logic [W-1:0]    head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= tag_i;
    end
  end

endmodule

// File: rtl/reqrsp_arbiter.sv
// Round-robin sharing of one req/rsp channel pair among N requesters.
// Responses return in request order and are steered by the tag FIFO head.
module reqrsp_arbiter
  import reqrsp_arb_pkg::*;
#(
  parameter int unsigned N     = NDefault,
  parameter int unsigned Wreq  = WreqDefault,
  parameter int unsigned Wrsp  = WrspDefault,
  parameter int unsigned DEPTH = DepthDefault,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N-1:0]      s_req_valid,
  input  logic [N*Wreq-1:0] s_req_data,
  output logic [N-1:0]      s_req_ready,
  output logic [N-1:0]      s_rsp_valid,
  output logic [Wrsp-1:0]   s_rsp_data,
  input  logic [N-1:0]      s_rsp_ready,
  output logic              m_req_valid,
  output logic [Wreq-1:0]   m_req_data,
  input  logic              m_req_ready,
  input  logic              m_rsp_valid,
  input  logic [Wrsp-1:0]   m_rsp_data,
  output logic              m_rsp_ready,
  output logic [CntW-1:0]   outstanding,
  output logic              orphan_err
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  arb_state_e      state_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic            orphan_q;

  rr_pick_t        pick;
  logic            grant_vld;
  logic [IdxW-1:0] grant_idx;
  logic            req_accept;
  logic            rsp_accept;
  logic [IdxW-1:0] tag_head;
  logic            tag_full;
  logic            tag_empty;

  // A locked grant is held even when full: locking only happens with space.
  always_comb begin
    pick = rr_pick(MaxN'(s_req_valid), 32'(rr_ptr_q), N);
    if (state_q == StLocked) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      grant_vld = ~tag_full & pick.found;
      grant_idx = pick.idx[IdxW-1:0];
    end
  end

  // Handshake outputs are gated so they read 0 for the whole reset assertion.
  assign m_req_valid = reset_n & grant_vld;
  assign m_req_data  = s_req_data[32'(grant_idx) * Wreq +: Wreq];
  assign req_accept  = m_req_valid & m_req_ready;
  assign s_req_ready = req_accept ? (N'(1) << grant_idx) : '0;

  assign m_rsp_ready = reset_n & ~tag_empty & s_rsp_ready[tag_head];
  assign s_rsp_valid = (reset_n & m_rsp_valid & ~tag_empty) ? (N'(1) << tag_head) : '0;
  assign s_rsp_data  = m_rsp_data;
  assign rsp_accept  = m_rsp_valid & m_rsp_ready;
  assign orphan_err  = orphan_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      orphan_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_vld && !m_req_ready) begin
            state_q    <= StLocked;
            lock_idx_q <= grant_idx;
          end
        end
        StLocked: begin
          if (m_req_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (req_accept) begin
        rr_ptr_q <= (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (m_rsp_valid && tag_empty) begin
        orphan_q <= 1'b1;
      end
    end
  end

  reqrsp_tag_fifo #(
    .W     (IdxW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (req_accept),
    .tag_i   (grant_idx),
    .pop_i   (rsp_accept),
    .head_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (outstanding)
  );

endmodule

// File: tb/tb_reqrsp_arbiter.sv
// Scenario bench for reqrsp_arbiter: expected grants and response steering are
// queued when stimulus is driven and popped when the DUT produces the transfer.
module tb_reqrsp_arbiter;
  import reqrsp_arb_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WREQ  = 32;
  localparam int unsigned WRSP  = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic [N*WREQ-1:0] s_req_data;
  logic [WRSP-1:0]   s_rsp_data, m_rsp_data;
  logic [WREQ-1:0]   m_req_data;
  logic              m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready, orphan_err;
  logic [CW-1:0]     outstanding;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              idx;
    logic [WRSP-1:0] data;
  } rsp_exp_t;

  int       req_exp_q[$];  // expected grant order
  int       tag_q[$];      // model of requester IDs in flight
  rsp_exp_t rsp_exp_q[$];  // expected steered responses

  always #5 clock = ~clock;

  reqrsp_arbiter #(
    .N     (N),
    .Wreq  (WREQ),
    .Wrsp  (WRSP),
    .DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .s_req_valid (s_req_valid),
    .s_req_data  (s_req_data),
    .s_req_ready (s_req_ready),
    .s_rsp_valid (s_rsp_valid),
    .s_rsp_data  (s_rsp_data),
    .s_rsp_ready (s_rsp_ready),
    .m_req_valid (m_req_valid),
    .m_req_data  (m_req_data),
    .m_req_ready (m_req_ready),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_data  (m_rsp_data),
    .m_rsp_ready (m_rsp_ready),
    .outstanding (outstanding),
    .orphan_err  (orphan_err)
  );

  function automatic logic [WREQ-1:0] req_word(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    s_req_valid = '1;
    m_req_ready = 1'b1;
    m_rsp_valid = 1'b1;
    s_rsp_ready = '1;
    #2;
    checks++;
    if (m_req_valid !== 1'b0 || s_req_ready !== '0 || s_rsp_valid !== '0 ||
        m_rsp_ready !== 1'b0 || outstanding !== '0 || orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mreqv=%b sreqr=%b srspv=%b mrspr=%b out=%0d orphan=%b, required all 0",
               m_req_valid, s_req_ready, s_rsp_valid, m_rsp_ready, outstanding, orphan_err);
    end
    s_req_valid = '0;
    m_rsp_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int e;
    for (int i = 0; i < 4; i++) req_exp_q.push_back(i);
    s_req_valid = '1;
    m_req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (outstanding !== CW'(tag_q.size())) begin
        errors++;
        $display("FAIL rr_outstanding cycle %0d: got %0d, required %0d", c, outstanding, tag_q.size());
      end
      checks++;
      if (req_exp_q.size() > 0) begin
        e = req_exp_q.pop_front();
        tag_q.push_back(e);
        if (m_req_valid !== 1'b1 || s_req_ready !== oh(e) || m_req_data !== req_word(e)) begin
          errors++;
          $display("FAIL rr_grant cycle %0d: valid=%b ready=%b data=%h, required valid=1 ready=%b data=%h",
                   c, m_req_valid, s_req_ready, m_req_data, oh(e), req_word(e));
        end
      end else if (m_req_valid !== 1'b0 || s_req_ready !== '0) begin
        errors++;
        $display("FAIL rr_full_stall cycle %0d: valid=%b ready=%b, required 0 and 0",
                 c, m_req_valid, s_req_ready);
      end
      tick();
    end
  endtask

  task automatic test_full_pop();
    rsp_exp_t r;
    // Full and a pop this cycle: no grant until the next cycle.
    m_rsp_valid = 1'b1;
    m_rsp_data  = 32'h5A5A_0000;
    s_rsp_ready = '1;
    rsp_exp_q.push_back('{idx: tag_q.pop_front(), data: 32'h5A5A_0000});
    #1;
    r = rsp_exp_q.pop_front();
    checks++;
    if (m_req_valid !== 1'b0 || s_rsp_valid !== oh(r.idx) || m_rsp_ready !== 1'b1 ||
        s_rsp_data !== r.data) begin
      errors++;
      $display("FAIL full_pop_same_cycle: mreqv=%b srspv=%b mrspr=%b data=%h, required 0 %b 1 %h",
               m_req_valid, s_rsp_valid, m_rsp_ready, s_rsp_data, oh(r.idx), r.data);
    end
    tick();
    m_rsp_valid = 1'b0;
    req_exp_q.push_back(0);
    #1;
    checks++;
    if (outstanding !== CW'(3) || m_req_valid !== 1'b1 || s_req_ready !== oh(req_exp_q[0])) begin
      errors++;
      $display("FAIL full_pop_next_grant: out=%0d valid=%b ready=%b, required 3 1 %b",
               outstanding, m_req_valid, s_req_ready, oh(req_exp_q[0]));
    end
    tag_q.push_back(req_exp_q.pop_front());
    tick();
    s_req_valid = '0;
    test_rsp_drain(4, 32'hD000_0000);
  endtask

  // Returns n responses (base, base+0x11, ...) and checks steering to the tag order.
  task automatic test_rsp_drain(input int n, input logic [WRSP-1:0] base);
    rsp_exp_t r;
    s_rsp_ready = '1;
    for (int k = 0; k < n; k++) begin
      m_rsp_valid = 1'b1;
      m_rsp_data  = base + WRSP'(32'h11 * k);
      checks++;
      if (outstanding !== CW'(tag_q.size())) begin
        errors++;
        $display("FAIL drain_outstanding %0d: got %0d, required %0d", k, outstanding, tag_q.size());
      end
      rsp_exp_q.push_back('{idx: tag_q.pop_front(), data: m_rsp_data});
      #1;
      r = rsp_exp_q.pop_front();
      checks++;
      if (s_rsp_valid !== oh(r.idx) || s_rsp_data !== r.data || m_rsp_ready !== 1'b1) begin
        errors++;
        $display("FAIL rsp_steer %0d: srspv=%b data=%h mrspr=%b, required %b %h 1",
                 k, s_rsp_valid, s_rsp_data, m_rsp_ready, oh(r.idx), r.data);
      end
      tick();
    end
    m_rsp_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== '0 || s_rsp_valid !== '0) begin
      errors++;
      $display("FAIL drain_done: out=%0d srspv=%b, required 0 0", outstanding, s_rsp_valid);
    end
    tick();
  endtask

  task automatic test_lock();
    int e;
    s_req_data[1*WREQ +: WREQ] = 32'h1234;
    s_req_valid = 4'b0010;
    m_req_ready = 1'b0;
    req_exp_q.push_back(1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) s_req_valid = 4'b0011;
      #1;
      checks++;
      if (m_req_valid !== 1'b1 || m_req_data !== 32'h1234 || s_req_ready !== '0) begin
        errors++;
        $display("FAIL lock_hold cycle %0d: valid=%b data=%h ready=%b, required 1 00001234 0000",
                 c, m_req_valid, m_req_data, s_req_ready);
      end
      tick();
    end
    m_req_ready = 1'b1;
    #1;
    e = req_exp_q.pop_front();
    checks++;
    if (s_req_ready !== oh(e) || m_req_data !== 32'h1234) begin
      errors++;
      $display("FAIL lock_accept: ready=%b data=%h, required %b 00001234", s_req_ready, m_req_data, oh(e));
    end
    tag_q.push_back(e);
    tick();
    req_exp_q.push_back(0);
    #1;
    e = req_exp_q.pop_front();
    checks++;
    if (s_req_ready !== oh(e) || m_req_data !== req_word(e)) begin
      errors++;
      $display("FAIL lock_next_grant: ready=%b data=%h, required %b %h",
               s_req_ready, m_req_data, oh(e), req_word(e));
    end
    tag_q.push_back(e);
    tick();
    s_req_valid = '0;
    s_req_data[1*WREQ +: WREQ] = req_word(1);
    test_rsp_drain(2, 32'hB000_0000);
  endtask

  task automatic test_rsp_order();
    int order[3] = '{2, 0, 3};
    m_req_ready = 1'b1;
    foreach (order[k]) begin
      s_req_valid = oh(order[k]);
      tag_q.push_back(order[k]);
      #1;
      checks++;
      if (s_req_ready !== oh(order[k]) || m_req_data !== req_word(order[k])) begin
        errors++;
        $display("FAIL order_req %0d: ready=%b data=%h, required %b %h",
                 k, s_req_ready, m_req_data, oh(order[k]), req_word(order[k]));
      end
      tick();
    end
    s_req_valid = '0;
    test_rsp_drain(3, 32'hAA);
  endtask

  task automatic test_backpressure();
    rsp_exp_t r;
    s_req_valid = oh(1);
    m_req_ready = 1'b1;
    tag_q.push_back(1);
    tick();
    s_req_valid = '0;
    m_rsp_valid = 1'b1;
    m_rsp_data  = 32'h77;
    s_rsp_ready = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (m_rsp_ready !== 1'b0 || s_rsp_valid !== oh(1) || outstanding !== CW'(1)) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: mrspr=%b srspv=%b out=%0d, required 0 0010 1",
                 c, m_rsp_ready, s_rsp_valid, outstanding);
      end
      tick();
    end
    s_rsp_ready = '1;
    rsp_exp_q.push_back('{idx: tag_q.pop_front(), data: 32'h77});
    #1;
    r = rsp_exp_q.pop_front();
    checks++;
    if (m_rsp_ready !== 1'b1 || s_rsp_valid !== oh(r.idx) || s_rsp_data !== r.data) begin
      errors++;
      $display("FAIL bp_release: mrspr=%b srspv=%b data=%h, required 1 %b %h",
               m_rsp_ready, s_rsp_valid, s_rsp_data, oh(r.idx), r.data);
    end
    tick();
    m_rsp_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== CW'(tag_q.size())) begin
      errors++;
      $display("FAIL bp_popped: out=%0d, required %0d", outstanding, tag_q.size());
    end
    tick();
  endtask

  task automatic test_orphan();
    m_rsp_valid = 1'b1;
    m_rsp_data  = 32'hDEAD;
    #1;
    checks++;
    if (m_rsp_ready !== 1'b0 || s_rsp_valid !== '0 || orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL orphan_cycle: mrspr=%b srspv=%b orphan=%b, required 0 0000 0",
               m_rsp_ready, s_rsp_valid, orphan_err);
    end
    tick();
    m_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (orphan_err !== 1'b1) begin
        errors++;
        $display("FAIL orphan_sticky cycle %0d: got %b, required 1", c, orphan_err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    m_req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_req_valid = oh(k);
      tag_q.push_back(k);
      tick();
    end
    s_req_valid = oh(2);
    m_req_ready = 1'b0;
    #1;
    checks++;
    if (m_req_valid !== 1'b1 || outstanding !== CW'(tag_q.size())) begin
      errors++;
      $display("FAIL pre_reset: valid=%b out=%0d, required 1 %0d", m_req_valid, outstanding, tag_q.size());
    end
    tick();
    #1;
    reset_n     = 1'b0;
    m_rsp_valid = 1'b1;
    s_rsp_ready = '1;
    m_req_ready = 1'b1;
    tag_q.delete();
    #1;
    checks++;
    if (m_req_valid !== 1'b0 || s_req_ready !== '0 || s_rsp_valid !== '0 || m_rsp_ready !== 1'b0 ||
        outstanding !== '0 || orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mreqv=%b sreqr=%b srspv=%b mrspr=%b out=%0d orphan=%b, required all 0",
               m_req_valid, s_req_ready, s_rsp_valid, m_rsp_ready, outstanding, orphan_err);
    end
    tick();
    reset_n = 1'b1;
    s_req_valid = '0;
    #1;
    checks++;
    if (m_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL late_rsp_ready: got %b, required 0", m_rsp_ready);
    end
    tick();
    m_rsp_valid = 1'b0;
    #1;
    checks++;
    if (orphan_err !== 1'b1) begin
      errors++;
      $display("FAIL late_rsp_orphan: got %b, required 1", orphan_err);
    end
    s_req_valid = 4'b1010;
    #1;
    checks++;
    if (s_req_ready !== oh(1) || m_req_data !== req_word(1)) begin
      errors++;
      $display("FAIL post_reset_grant: ready=%b data=%h, required 0010 %h",
               s_req_ready, m_req_data, req_word(1));
    end
    tick();
    s_req_valid = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) s_req_data[i*WREQ +: WREQ] = req_word(i);
    s_req_valid = '0;
    s_rsp_ready = '0;
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_data  = '0;
    test_reset();
    test_round_robin();
    test_full_pop();
    test_lock();
    test_rsp_order();
    test_backpressure();
    test_orphan();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule
